pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage RV32I pipeline. It drives the load enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC load. It merges the one-cycle response pulses of the instruction and data caches, so the pipeline advances only when every outstanding access has completed. It also inserts load-use bubbles and squashes the wrong path on a branch mispredict resolved in MEM.

---
 rtl/rv32i_types.sv | 12 +
 rtl/hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: pipeline_ctrl sequencer states and register constants.
package rv32i_types;

   typedef enum logic [1:0] {
      S_WAIT_BOTH = 2'd0,
      S_WAIT_D    = 2'd1,
      S_WAIT_I    = 2'd2
   } pipe_ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: ID source against an EX-stage load destination.
module hazard_detect
   import rv32i_types::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_is_load,
   output logic       lu_hazard
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit   = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit   = id_uses_rs2 && (id_rs2 == ex_rd);
      // x0 is never a real dependency, even when a load names it.
      lu_hazard = ex_is_load && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage RV32I pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
   import rv32i_types::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       imem_resp,
   input  logic       dmem_req,
   input  logic       dmem_resp,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_is_load,
   input  logic       mem_br_mispredict,
   output logic       imem_read,
   output logic       dmem_go,
   output logic       pc_load,
   output logic       if_id_load,
   output logic       id_ex_load,
   output logic       ex_mem_load,
   output logic       mem_wb_load,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flushes,
   output logic [31:0] perf_lu_stalls
`endif
);

   pipe_ctrl_state_t state_q;
   pipe_ctrl_state_t state_d;

   logic i_ok;
   logic d_ok;
   logic adv;
   logic go;
   logic lu_hazard;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_is_load  (ex_is_load),
      .lu_hazard   (lu_hazard)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_WAIT_BOTH;
      else        state_q <= state_d;
   end

   always_comb begin
      i_ok = imem_resp || (state_q == S_WAIT_D);
      d_ok = !dmem_req || dmem_resp || (state_q == S_WAIT_I);
      adv  = i_ok && d_ok;
      // Outputs are forced quiet while reset is held, independent of state.
      go   = adv && rst_n;

      state_d = state_q;
      if (adv)
         state_d = S_WAIT_BOTH;
      else if (imem_resp && !d_ok)
         state_d = S_WAIT_D;
      else if (dmem_req && dmem_resp && !i_ok)
         state_d = S_WAIT_I;

      imem_read    = rst_n && (state_q != S_WAIT_D);
      dmem_go      = rst_n && dmem_req && (state_q != S_WAIT_I);
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;

      if (go) begin
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
         if (mem_br_mispredict) begin
            pc_load      = 1'b1;
            if_id_load   = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (lu_hazard) begin
            // Hold PC and IF/ID so the dependent instruction is re-presented.
            id_ex_flush = 1'b1;
         end else begin
            pc_load    = 1'b1;
            if_id_load = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
         perf_lu_stalls    <= '0;
      end else begin
         if (!adv)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (adv && mem_br_mispredict)
            perf_flushes <= perf_flushes + 32'd1;
         if (adv && lu_hazard && !mem_br_mispredict)
            perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; perf ports checked when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

   logic       clk;
   logic       rst_n;
   logic       imem_resp;
   logic       dmem_req;
   logic       dmem_resp;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] ex_rd;
   logic       ex_is_load;
   logic       mem_br_mispredict;
   logic       imem_read;
   logic       dmem_go;
   logic       pc_load;
   logic       if_id_load;
   logic       id_ex_load;
   logic       ex_mem_load;
   logic       mem_wb_load;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       ex_mem_flush;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flushes;
   logic [31:0] perf_lu_stalls;
`endif

   int unsigned n_vec;
   int unsigned n_bad;

   // {imem_read, dmem_go, pc_load, if_id, id_ex, ex_mem, mem_wb loads, if_id, id_ex, ex_mem flushes}
   logic [9:0] outs;
   assign outs = {imem_read, dmem_go, pc_load, if_id_load, id_ex_load, ex_mem_load,
                  mem_wb_load, if_id_flush, id_ex_flush, ex_mem_flush};

   localparam logic [9:0] O_ZERO    = 10'b00_0_0000_000;
   localparam logic [9:0] O_RUN     = 10'b10_1_1111_000;
   localparam logic [9:0] O_BUBBLE  = 10'b10_0_0111_010;
   localparam logic [9:0] O_SQUASH  = 10'b10_1_1111_111;
   localparam logic [9:0] O_WAIT_ID = 10'b11_0_0000_000;
   localparam logic [9:0] O_WAIT_D  = 10'b01_0_0000_000;
   localparam logic [9:0] O_ADV_D   = 10'b01_1_1111_000;
   localparam logic [9:0] O_WAIT_I  = 10'b10_0_0000_000;

   pipeline_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_resp         (imem_resp),
      .dmem_req          (dmem_req),
      .dmem_resp         (dmem_resp),
      .id_rs1            (id_rs1),
      .id_rs2            (id_rs2),
      .id_uses_rs1       (id_uses_rs1),
      .id_uses_rs2       (id_uses_rs2),
      .ex_rd             (ex_rd),
      .ex_is_load        (ex_is_load),
      .mem_br_mispredict (mem_br_mispredict),
      .imem_read         (imem_read),
      .dmem_go           (dmem_go),
      .pc_load           (pc_load),
      .if_id_load        (if_id_load),
      .id_ex_load        (id_ex_load),
      .ex_mem_load       (ex_mem_load),
      .mem_wb_load       (mem_wb_load),
      .if_id_flush       (if_id_flush),
      .id_ex_flush       (id_ex_flush),
      .ex_mem_flush      (ex_mem_flush)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes),
      .perf_lu_stalls    (perf_lu_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are already set (just after a rising edge); check at the falling edge, then clock.
   task automatic cycle_check(input string tag, input logic [9:0] exp);
      @(negedge clk);
      check(tag, {22'd0, outs}, {22'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [1:0] exp);
      check(tag, {30'd0, dut.state_q}, {30'd0, exp});
   endtask

   task automatic idle_inputs();
      imem_resp         = 1'b0;
      dmem_req          = 1'b0;
      dmem_resp         = 1'b0;
      id_rs1            = 5'd0;
      id_rs2            = 5'd0;
      id_uses_rs1       = 1'b0;
      id_uses_rs2       = 1'b0;
      ex_rd             = 5'd0;
      ex_is_load        = 1'b0;
      mem_br_mispredict = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      idle_inputs();
      rst_n     = 1'b0;
      imem_resp = 1'b1;
      dmem_req  = 1'b1;
      dmem_resp = 1'b1;
      #12;
      check("reset_outs", {22'd0, outs}, {22'd0, O_ZERO});
      check_state("reset_state", 2'd0);
      idle_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single-cycle hits, no data access.
      imem_resp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_state("hit_state", 2'd0);
         cycle_check("hit_run", O_RUN);
      end

      // icache at cycle 0, dcache at cycle 3.
      dmem_req  = 1'b1;
      cycle_check("dlate_c0", O_WAIT_ID);
      imem_resp = 1'b0;
      for (int i = 1; i < 3; i++) begin
         check_state("dlate_state", 2'd1);
         cycle_check("dlate_wait", O_WAIT_D);
      end
      dmem_resp = 1'b1;
      check_state("dlate_state3", 2'd1);
      cycle_check("dlate_adv", O_ADV_D);
      dmem_resp = 1'b0;
      dmem_req  = 1'b0;
      imem_resp = 1'b1;
      check_state("dlate_back", 2'd0);
      cycle_check("dlate_after", O_RUN);

      // dcache at cycle 1, icache at cycle 4.
      imem_resp = 1'b0;
      dmem_req  = 1'b1;
      cycle_check("ilate_c0", O_WAIT_ID);
      dmem_resp = 1'b1;
      cycle_check("ilate_c1", O_WAIT_ID);
      dmem_resp = 1'b0;
      for (int i = 2; i < 4; i++) begin
         check_state("ilate_state", 2'd2);
         cycle_check("ilate_wait", O_WAIT_I);
      end
      imem_resp = 1'b1;
      cycle_check("ilate_adv", O_WAIT_I | O_RUN);
      dmem_req = 1'b0;
      check_state("ilate_back", 2'd0);
      cycle_check("ilate_after", O_RUN);

      // lw x5 in EX, add x6,x5,x1 in ID.
      ex_is_load  = 1'b1;
      ex_rd       = 5'd5;
      id_rs1      = 5'd5;
      id_rs2      = 5'd1;
      id_uses_rs1 = 1'b1;
      id_uses_rs2 = 1'b1;
      cycle_check("lu_rs1", O_BUBBLE);
      id_rs1 = 5'd1;
      id_rs2 = 5'd5;
      cycle_check("lu_rs2", O_BUBBLE);
      id_uses_rs2 = 1'b0;
      cycle_check("lu_rs2_unused", O_RUN);
      ex_rd       = 5'd0;
      id_rs1      = 5'd0;
      id_uses_rs1 = 1'b1;
      cycle_check("lu_x0", O_RUN);
      ex_rd      = 5'd5;
      id_rs1     = 5'd5;
      ex_is_load = 1'b0;
      cycle_check("lu_not_load", O_RUN);

      // Mispredict over a load-use hazard, counters fresh from reset.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      ex_is_load        = 1'b1;
      mem_br_mispredict = 1'b1;
      cycle_check("squash", O_SQUASH);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_flushes", perf_flushes, 32'd1);
      check("perf_lu", perf_lu_stalls, 32'd0);
      check("perf_stall0", perf_stall_cycles, 32'd0);
`endif
      // Mispredict cannot act while frozen.
      imem_resp = 1'b0;
      dmem_req  = 1'b1;
      cycle_check("squash_frozen", O_WAIT_ID);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_stall1", perf_stall_cycles, 32'd1);
      check("perf_flushes_hold", perf_flushes, 32'd1);
`endif

      // Reset asserted while in S_WAIT_I.
      idle_inputs();
      dmem_req  = 1'b1;
      dmem_resp = 1'b1;
      cycle_check("rst_enter", O_WAIT_ID);
      dmem_resp = 1'b0;
      check_state("rst_in_wait_i", 2'd2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {22'd0, outs}, {22'd0, O_ZERO});
      check_state("rst_mid_state", 2'd0);
      #2;
      idle_inputs();
      rst_n = 1'b1;
      #1;
      check_state("rst_release_state", 2'd0);
      cycle_check("rst_release", O_WAIT_I);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
